// File: rtl/riscv_pkg.sv
// ============================================================================
// Module      : riscv_pkg
// Description : Shared constants and FSM state encoding for the fetch-side
//               instruction-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

  // Canonical NOP (addi x0,x0,0). It is returned on faulting fetches so the
  // pipeline always sees a harmless instruction.
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Responder FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/imem_array.sv
// ============================================================================
// Module      : imem_array
// Description : Synchronous-write, registered-read instruction word array.
//               A read and a write to the same word on the same edge returns
//               the old contents.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_array
  import riscv_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  // Storage write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read; non-blocking semantics give read-before-write on collision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= 32'd0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/imem_fetch_responder.sv
// ============================================================================
// Module      : imem_fetch_responder
// Description : Fixed-latency instruction fetch responder with flush support,
//               address range/alignment checking and a program-load port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_fetch_responder
  import riscv_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          LATENCY     = 2,
  parameter int          AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req_valid,
  input  logic [31:0]   i_req_addr,
  output logic          o_req_ready,
  input  logic          i_flush,
  output logic          o_rsp_valid,
  output logic [31:0]   o_rsp_inst,
  output logic          o_rsp_err,
  input  logic          i_rsp_ready,
  input  logic          i_prog_we,
  input  logic [AW-1:0] i_prog_addr,
  input  logic [31:0]   i_prog_data
);

  localparam logic [31:0] c_SPAN     = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  c_CNT_INIT = 4'(LATENCY - 1);
  localparam logic        c_LAT_ONE  = (LATENCY == 1);

  fetch_state_t r_state;
  logic [3:0]   r_cnt;
  logic [31:0]  r_addr;
  logic         r_rsp_valid;
  logic         r_rsp_err;

  logic [31:0]  w_chk_addr;
  logic [31:0]  w_offset;
  logic         w_err;
  logic         w_enter_resp;
  logic [31:0]  w_rdata;

  // With LATENCY=1 the array is read on the accept edge, so the check must
  // look at the live request address rather than the latched one.
  assign w_chk_addr = (r_state == IDLE) ? i_req_addr : r_addr;
  assign w_offset   = w_chk_addr - BASE_ADDR;
  // Wrapping subtraction folds addr < BASE_ADDR into the upper-bound test
  assign w_err      = (w_chk_addr[1:0] != 2'b00) || (w_offset >= c_SPAN);

  assign w_enter_resp = ((r_state == IDLE) && i_req_valid && c_LAT_ONE) ||
                        ((r_state == WAIT) && !i_flush && (r_cnt == 4'd0));

  imem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_imem_array (
    .clk     (clk),
    .rst     (rst),
    .i_we    (i_prog_we),
    .i_waddr (i_prog_addr),
    .i_wdata (i_prog_data),
    .i_re    (w_enter_resp),
    .i_raddr (w_offset[2 +: AW]),
    .o_rdata (w_rdata)
  );

  // Request/latency/response sequencing with registered response flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_addr      <= 32'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // Flush is ignored here: a same-edge request carries the new PC
          if (i_req_valid) begin
            r_addr <= i_req_addr;
            r_cnt  <= c_CNT_INIT;
            if (c_LAT_ONE) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= w_err;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (i_flush) begin
            r_state <= IDLE;
          end else if (r_cnt == 4'd0) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_err;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          if (i_flush || i_rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_req_ready = (r_state == IDLE);
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_err   = r_rsp_err;
  // Both sources are registers that reset to zero, so the word reads 0 in reset
  assign o_rsp_inst  = r_rsp_err ? NOP_INST : w_rdata;

endmodule

`default_nettype wire
